// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared widths, op encodings and FSM states for the HI/LO unit
package muldiv_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  localparam logic [DATA_W-1:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - unsigned shift-add multiply / restoring divide, one bit per step
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         last
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  b_q;
  logic          is_div_q;
  logic [CW-1:0] cnt;

  logic [W:0]    add;
  logic [W:0]    rem_sh;
  logic          fits;
  logic [W-1:0]  sub;

  // hi:lo is the product accumulator for multiply, remainder:quotient for divide
  always_comb begin
    add    = {1'b0, hi} + {1'b0, b_q};
    rem_sh = {hi, lo[W-1]};
    fits   = rem_sh >= {1'b0, b_q};
    sub    = rem_sh[W-1:0] - b_q;
  end

  assign last = step && (cnt == CW'(W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      hi       <= '0;
      lo       <= a;
      b_q      <= b;
      is_div_q <= is_div;
      cnt      <= '0;
    end else if (step) begin
      cnt <= cnt + CW'(1);
      if (is_div_q) begin
        hi <= fits ? sub : rem_sh[W-1:0];
        lo <= {lo[W-2:0], fits};
      end else if (lo[0]) begin
        {hi, lo} <= {add, lo[W-1:1]};
      end else begin
        {hi, lo} <= {1'b0, hi, lo[W-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = muldiv_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] OpA,
  input  logic [DATA_W-1:0] OpB,
  input  logic              HiWr,
  input  logic              LoWr,
  input  logic [DATA_W-1:0] WrData,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  state_t state;

  logic              is_div_q, sa_q, sb_q, div0_q;
  logic [DATA_W-1:0] a_raw_q;

  logic              launch, is_div, is_signed, sa, sb;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [DATA_W-1:0] it_hi, it_lo;
  logic              it_last;

  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   q_fix, r_fix;

  always_comb begin
    launch    = (state == IDLE) && Start;
    is_div    = (Op == OP_DIV) || (Op == OP_DIVU);
    is_signed = (Op == OP_MULT) || (Op == OP_DIV);
    sa        = is_signed && OpA[DATA_W-1];
    sb        = is_signed && OpB[DATA_W-1];
    mag_a     = sa ? -OpA : OpA;
    mag_b     = sb ? -OpB : OpB;
  end

  muldiv_iter #(.W(DATA_W)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (launch),
    .step   (state == RUN),
    .is_div (is_div),
    .a      (mag_a),
    .b      (mag_b),
    .hi     (it_hi),
    .lo     (it_lo),
    .last   (it_last)
  );

  // Magnitudes were used in the datapath; restore signs here (0x80000000/-1 wraps naturally)
  always_comb begin
    prod     = {it_hi, it_lo};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    q_fix    = (sa_q ^ sb_q) ? -it_lo : it_lo;
    r_fix    = sa_q ? -it_hi : it_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      Hi       <= '0;
      Lo       <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      a_raw_q  <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (HiWr) Hi <= WrData;
          if (LoWr) Lo <= WrData;
          if (Start) begin
            is_div_q <= is_div;
            sa_q     <= sa;
            sb_q     <= sb;
            div0_q   <= is_div && (OpB == '0);
            a_raw_q  <= OpA;
            Busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (it_last) state <= FIX;
        end
        FIX: begin
          if (!is_div_q) begin
            {Hi, Lo} <= prod_fix;
          end else if (div0_q) begin
            Hi <= a_raw_q;
            Lo <= DIV0_LO;
          end else begin
            Hi <= r_fix;
            Lo <= q_fix;
          end
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vectors checked against a transaction-level HI/LO model
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] OpA, OpB;
  logic         HiWr, LoWr;
  logic [W-1:0] WrData;
  logic         Busy, Done;
  logic [W-1:0] Hi, Lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .Start  (Start),
    .Op     (Op),
    .OpA    (OpA),
    .OpB    (OpB),
    .HiWr   (HiWr),
    .LoWr   (LoWr),
    .WrData (WrData),
    .Busy   (Busy),
    .Done   (Done),
    .Hi     (Hi),
    .Lo     (Lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Architectural result of one op, straight from the MIPS arithmetic rules
  function automatic logic [63:0] mdl(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub, q, r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return 64'(ua * ub);
      default: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin q = sa / sb; r = sa % sb; end
        else begin q = ua / ub; r = ua % ub; end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  logic [W-1:0]  m_hi, m_lo;
  logic [63:0]   m_pend;
  logic          m_busy, m_done;
  int            m_left = 0;
  bit            model_valid = 0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_hi = '0; m_lo = '0; m_left = 0; model_valid = 1;
    end else if (m_left == 0) begin
      if (HiWr) m_hi = WrData;
      if (LoWr) m_lo = WrData;
      if (Start) begin
        m_pend = mdl(Op, OpA, OpB);
        m_left = W + 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        {m_hi, m_lo} = m_pend;
        m_done = 1'b1;
      end
    end
    m_busy = (m_left != 0);
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("busy", 64'(Busy), 64'(m_busy));
      chk("done", 64'(Done), 64'(m_done));
      chk("hi",   64'(Hi),   64'(m_hi));
      chk("lo",   64'(Lo),   64'(m_lo));
    end
  end

  task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input bit inject, input bit wr_start);
    int  k;
    int  busy_n;
    bit  seen;
    @(negedge clk);
    Op = op; OpA = a; OpB = b; Start = 1'b1;
    if (wr_start) begin HiWr = 1'b1; WrData = 32'h0000_CAFE; end
    busy_n = 0;
    seen   = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      Start = 1'b0; HiWr = 1'b0; LoWr = 1'b0;
      if (wr_start && k == 1) chk({nm, "_wr_at_start"}, 64'(Hi), 64'h0000_CAFE);
      if (inject && k == 5) begin
        Start = 1'b1; Op = 2'b01; OpA = 32'h1111; OpB = 32'h2222;
        HiWr = 1'b1; LoWr = 1'b1; WrData = 32'hDEAD_BEEF;
      end
      if (Busy) busy_n++;
      if (Done) begin seen = 1; break; end
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    chk({nm, "_latency"}, 64'(k), 64'd34);
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'd33);
    chk({nm, "_hi"}, 64'(Hi), 64'(eh));
    chk({nm, "_lo"}, 64'(Lo), 64'(el));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; Start = 1'b0; Op = 2'b00; OpA = '0; OpB = '0;
    HiWr = 1'b0; LoWr = 1'b0; WrData = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_hi", 64'(Hi), 64'd0);
    chk("reset_lo", 64'(Lo), 64'd0);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
    run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
    run_op("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0);
    run_op("div_m7d2",  2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    run_op("divu_7d2",  2'b11, 32'd7,         32'd2,         32'd1,         32'd3,         0, 0);
    run_op("div_7dm2",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 0);
    run_op("div_by0",   2'b10, 32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, 0, 0);
    run_op("divu_by0",  2'b11, 32'h8765_4321, 32'd0,         32'h8765_4321, 32'hFFFF_FFFF, 0, 0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0, 0);

    @(negedge clk); HiWr = 1'b1; WrData = 32'hA5A5_A5A5;
    @(negedge clk); HiWr = 1'b0;
    chk("mthi_hi", 64'(Hi), 64'hA5A5_A5A5);
    chk("mthi_lo_kept", 64'(Lo), 64'h8000_0000);
    HiWr = 1'b1; LoWr = 1'b1; WrData = 32'h1234_5678;
    @(negedge clk); HiWr = 1'b0; LoWr = 1'b0;
    chk("mthilo_hi", 64'(Hi), 64'h1234_5678);
    chk("mthilo_lo", 64'(Lo), 64'h1234_5678);

    run_op("divu_inject", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1, 0);
    run_op("multu_wr_start", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 0, 1);

    @(negedge clk);
    Op = 2'b01; OpA = 32'hFFFF; OpB = 32'hFFFF; Start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", 64'(Busy), 64'd0);
    chk("rst_mid_done", 64'(Done), 64'd0);
    chk("rst_mid_hi", 64'(Hi), 64'd0);
    chk("rst_mid_lo", 64'(Lo), 64'd0);
    repeat (30) @(negedge clk);
    chk("rst_mid_no_late_lo", 64'(Lo), 64'd0);

    run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
